// File: rtl/wavegen_pkg.sv
// Shared types and constants for the wavegen channel datapath.
// The optional sine mode is controlled by the WAVEGEN_SINE_EN macro (see wavegen_channel).
package wavegen_pkg;

    localparam int PWORD_W      = 16;   // phase word fed to the shapers
    localparam int OFST_W       = 16;
    localparam int AMPL_W       = 16;
    localparam int DCYC_W       = 16;
    localparam int MODE_W       = 3;
    localparam int SINE_IDX_W   = 10;   // top phase-word bits that address the folded sine ROM

    localparam logic [AMPL_W-1:0] AMPL_UNITY = 16'h8000;   // 1.0 in Q1.15

    localparam logic signed [15:0] SAMPLE_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAMPLE_MIN = 16'sh8000;

    typedef enum logic [MODE_W-1:0] {
        WG_DC   = 3'd0,
        WG_SAW  = 3'd1,
        WG_TRI  = 3'd2,
        WG_SQR  = 3'd3,
        WG_SINE = 3'd4
    } wg_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } wg_state_e;

    // Clamp the offset-corrected sum into the signed 16-bit sample range.
    function automatic logic signed [15:0] sat16(input logic signed [18:0] v);
        if (v > 19'sd32767) begin
            return SAMPLE_MAX;
        end else if (v < -19'sd32768) begin
            return SAMPLE_MIN;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/wavegen_sine_lut.sv
// Quarter-wave sine ROM with quadrant folding.
// Only instantiated when WAVEGEN_SINE_EN is defined; purely combinational.
// Only the top 10 bits of the phase word matter: 2 quadrant bits + 8 index bits,
// so the port carries just those.
module wavegen_sine_lut
    import wavegen_pkg::*;
(
    input  logic [SINE_IDX_W-1:0] phase_hi_i,
    output logic signed [15:0]    sine_o
);

    localparam real PI = 3.14159265358979323846;

    // Table entry k = round(32767 * sin(2*pi*k/1024)), k in [0, 256].
    function automatic logic signed [15:0] lut_val(input int k);
        real x;
        x = 32767.0 * $sin(2.0 * PI * k / 1024.0);
        return 16'($rtoi(x + 0.5));
    endfunction

    logic signed [15:0] rom [0:256];

    for (genvar k = 0; k <= 256; k++) begin : g_rom
        assign rom[k] = lut_val(k);
    end

    logic [1:0]         quad;
    logic [7:0]         idx;
    logic [8:0]         addr;
    logic signed [15:0] mag;

    assign quad = phase_hi_i[9:8];
    assign idx  = phase_hi_i[7:0];

    // Odd quadrants walk the quarter wave backwards; the upper half is negated.
    always_comb begin
        addr = {1'b0, idx};
        if (quad[0]) begin
            addr = 9'd256 - {1'b0, idx};
        end
        mag    = rom[addr];
        sine_o = quad[1] ? -mag : mag;
    end

endmodule

// File: rtl/wavegen_channel.sv
// One waveform-synthesis channel: phase accumulator, run/cycle-count FSM,
// waveform shaper, Q1.15 gain, offset and saturation, two-stage output pipeline.
// Optional feature macro: WAVEGEN_SINE_EN enables mode 4 (sine) through
// wavegen_sine_lut; without it mode 4 produces 0 and no ROM is built.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for run_i; ticks ignored
// RUN     | ticks advance phase and emit samples; busy_o high
// DONE    | cycle budget reached; ticks ignored until run_i drops
module wavegen_channel
    import wavegen_pkg::*;
#(
    parameter int PHASE_W  = 32,
    parameter int SAMPLE_W = 16,
    parameter int CYCLE_W  = 16
) (
    input  logic                       S_AXI_ACLK,
    input  logic                       S_AXI_ARESET,
    input  logic                       run_i,
    input  logic [MODE_W-1:0]          mode_i,
    input  logic [PHASE_W-1:0]         frq_i,
    input  logic [OFST_W-1:0]          ofst_i,
    input  logic [AMPL_W-1:0]          ampl_i,
    input  logic [DCYC_W-1:0]          dcyc_i,
    input  logic [CYCLE_W-1:0]         cycl_i,
    input  logic                       sample_tick_i,
    output logic signed [SAMPLE_W-1:0] sample_o,
    output logic                       sample_valid_o,
    output logic                       busy_o,
    output logic                       done_o
);

    wg_state_e             state_q;
    logic [PHASE_W-1:0]    phase_q;
    logic [CYCLE_W-1:0]    count_q;

    logic [PHASE_W:0]      phase_sum;
    logic                  carry;
    logic [CYCLE_W:0]      count_inc;
    logic                  cycle_hit;
    logic                  tick_run;
    logic                  flush;

    logic [PWORD_W-1:0]    pword;
    logic [15:0]           tri_lin;
    logic signed [15:0]    raw_c;

    logic                  v1_q;
    logic signed [15:0]    raw_q;
    logic [AMPL_W-1:0]     ampl_q;
    logic signed [15:0]    ofst_q;

    logic signed [32:0]    raw_x;
    logic signed [32:0]    ampl_x;
    logic signed [32:0]    prod_c;
    logic signed [17:0]    scaled_c;
    logic signed [18:0]    sum_c;

    assign phase_sum = {1'b0, phase_q} + {1'b0, frq_i};
    assign carry     = phase_sum[PHASE_W];
    assign count_inc = {1'b0, count_q} + {{CYCLE_W{1'b0}}, 1'b1};
    // count+1 is compared unsaturated so a pinned counter still terminates.
    assign cycle_hit = carry && (cycl_i != '0) && (count_inc >= {1'b0, cycl_i});

    // A tick only counts in RUN with run_i still high; a run edge in the same clock wins.
    assign tick_run  = (state_q == ST_RUN) && run_i && sample_tick_i;
    // Leaving RUN through run_i discards whatever is still in the pipeline.
    assign flush     = (state_q == ST_RUN) && !run_i;

    // Sample shaping uses the pre-increment phase, so the first sample sees phase 0.
    assign pword   = phase_q[PHASE_W-1 -: PWORD_W];
    assign tri_lin = {pword[14:0], 1'b0};

`ifdef WAVEGEN_SINE_EN
    logic signed [15:0] sine_c;

    wavegen_sine_lut u_sine_lut (
        .phase_hi_i (pword[PWORD_W-1 -: SINE_IDX_W]),
        .sine_o     (sine_c)
    );
`endif

    // Waveform shaper: maps the phase word to a full-scale signed sample.
    always_comb begin
        raw_c = '0;
        case (mode_i)
            WG_DC:   raw_c = SAMPLE_MAX;
            // p - 32768 is just the MSB flipped.
            WG_SAW:  raw_c = {~pword[15], pword[14:0]};
            // Rising half: 2p' - 32768 (MSB flip); falling half: 32767 - 2p' wraps correctly in 16 bits.
            WG_TRI:  raw_c = pword[15] ? (16'h7FFF - tri_lin) : {~tri_lin[15], tri_lin[14:0]};
            WG_SQR:  raw_c = (pword < dcyc_i) ? SAMPLE_MAX : SAMPLE_MIN;
`ifdef WAVEGEN_SINE_EN
            WG_SINE: raw_c = sine_c;
`endif
            default: raw_c = '0;
        endcase
    end

    // Run/cycle FSM with phase accumulator, cycle counter and registered status outputs.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            count_q <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (run_i) begin
                        state_q <= ST_RUN;
                        phase_q <= '0;
                        count_q <= '0;
                        busy_o  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!run_i) begin
                        state_q <= ST_IDLE;
                        busy_o  <= 1'b0;
                    end else if (sample_tick_i) begin
                        phase_q <= phase_sum[PHASE_W-1:0];
                        if (carry && !(&count_q)) begin
                            count_q <= count_inc[CYCLE_W-1:0];
                        end
                        if (cycle_hit) begin
                            state_q <= ST_DONE;
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (!run_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: capture the shaped sample with the gain/offset in force at this tick.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            v1_q   <= 1'b0;
            raw_q  <= '0;
            ampl_q <= '0;
            ofst_q <= '0;
        end else begin
            v1_q <= tick_run;
            if (tick_run) begin
                raw_q  <= raw_c;
                ampl_q <= ampl_i;
                ofst_q <= ofst_i;
            end
        end
    end

    // Gain is unsigned Q1.15, so it is zero-extended before the signed multiply.
    assign raw_x    = {{17{raw_q[15]}}, raw_q};
    assign ampl_x   = {17'd0, ampl_q};
    assign prod_c   = raw_x * ampl_x;
    assign scaled_c = prod_c[32:15];
    assign sum_c    = {scaled_c[17], scaled_c} + {{3{ofst_q[15]}}, ofst_q};

    // Stage 2: saturated output register; sample_o holds between strobes.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            sample_o       <= '0;
            sample_valid_o <= 1'b0;
        end else begin
            sample_valid_o <= v1_q && !flush;
            if (v1_q && !flush) begin
                sample_o <= sat16(sum_c);
            end
        end
    end

endmodule

// File: tb/tb_wavegen_channel.sv
// Self-checking bench for wavegen_channel: directed test-plan cases with literal
// expectations, then randomized stimulus against a behavioural reference model.
module tb_wavegen_channel;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        run  = 1'b0;
    logic        tick = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic [31:0] frq  = 32'd0;
    logic [15:0] ofst = 16'd0;
    logic [15:0] ampl = 16'h8000;
    logic [15:0] dcyc = 16'd0;
    logic [15:0] cycl = 16'd0;

    logic [15:0] sample;
    logic        valid;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    wavegen_channel dut (
        .S_AXI_ACLK     (clk),
        .S_AXI_ARESET   (rst),
        .run_i          (run),
        .mode_i         (mode),
        .frq_i          (frq),
        .ofst_i         (ofst),
        .ampl_i         (ampl),
        .dcyc_i         (dcyc),
        .cycl_i         (cycl),
        .sample_tick_i  (tick),
        .sample_o       (sample),
        .sample_valid_o (valid),
        .busy_o         (busy),
        .done_o         (done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        int due;
        int val;
    } exp_t;

    exp_t        q[$];
    int          n_edge    = 0;
    int          done_edge = -10;
    int          last_val  = 0;
    bit          m_run     = 1'b0;
    bit          m_fin     = 1'b0;
    logic [31:0] m_phase   = 32'd0;
    int          m_count   = 0;
    longint      m_sum;
    int          m_val;

    int cap[$];
    int lit[$];
    int done_cnt = 0;

    function automatic int sine_tab(int k);
        real x;
        x = 32767.0 * $sin(2.0 * 3.14159265358979323846 * k / 1024.0);
        return $rtoi(x + 0.5);
    endfunction

    function automatic int sine_ref(int p);
        int i, quad, v;
        i    = (p / 64) % 256;
        quad = p / 16384;
        v    = (quad % 2 == 1) ? sine_tab(256 - i) : sine_tab(i);
        return (quad >= 2) ? -v : v;
    endfunction

    function automatic int shape(int p, int md, int dc);
        case (md)
            0: return 32767;
            1: return p - 32768;
            2: return (p < 32768) ? 2 * p - 32768 : 32767 - 2 * (p - 32768);
            3: return (p < dc) ? 32767 : -32768;
`ifdef WAVEGEN_SINE_EN
            4: return sine_ref(p);
`endif
            default: return 0;
        endcase
    endfunction

    function automatic int scale(int raw, int a, int o);
        longint prod, sc, s;
        prod = longint'(raw) * longint'(a);
        sc   = prod >>> 15;
        s    = sc + longint'(o);
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return int'(s);
    endfunction

    // Model advances on the same edges as the DUT, reading the bench-driven inputs.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_run     = 1'b0;
            m_fin     = 1'b0;
            m_phase   = 32'd0;
            m_count   = 0;
            done_edge = -10;
        end else begin
            n_edge++;
            if (m_run) begin
                if (!run) begin
                    m_run = 1'b0;
                    while (q.size() > 0 && q[$].due >= n_edge) void'(q.pop_back());
                end else if (tick) begin
                    m_val = scale(shape(int'(m_phase[31:16]), int'(mode), int'(dcyc)),
                                  int'(ampl), int'($signed(ofst)));
                    q.push_back('{n_edge + 1, m_val});
                    m_sum   = longint'(m_phase) + longint'(frq);
                    m_phase = m_sum[31:0];
                    if (m_sum >= 64'h1_0000_0000) begin
                        if (cycl != 0 && m_count + 1 >= int'(cycl)) begin
                            m_run     = 1'b0;
                            m_fin     = 1'b1;
                            done_edge = n_edge;
                        end
                        if (m_count < 65535) m_count++;
                    end
                end
            end else if (m_fin) begin
                if (!run) m_fin = 1'b0;
            end else if (run) begin
                m_run   = 1'b1;
                m_phase = 32'd0;
                m_count = 0;
            end
        end
    end

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at time %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, sampled on the falling edge.
    always @(negedge clk) begin
        bit ev;
        if (rst) last_val = 0;
        ev = (q.size() > 0 && q[0].due == n_edge);
        if (ev) begin
            last_val = q[0].val;
            void'(q.pop_front());
        end
        chk("sample_valid", int'(valid), int'(ev));
        chk("sample", int'($signed(sample)), last_val);
        chk("busy", int'(busy), int'(m_run));
        chk("done", int'(done), int'(done_edge == n_edge && !rst));
        if (valid) cap.push_back(int'($signed(sample)));
        if (done) done_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ticks(int n, int gap);
        repeat (n) begin
            tick = 1'b1;
            idle(1);
            tick = 1'b0;
            idle(gap - 1);
        end
    endtask

    task automatic check_cap(string nm);
        chk({nm, "_count"}, cap.size(), lit.size());
        for (int i = 0; i < lit.size(); i++) begin
            chk(nm, (i < cap.size()) ? cap[i] : 999999, lit[i]);
        end
    endtask

    task automatic one_shot(string nm, logic [2:0] md, logic [31:0] f, logic [15:0] a,
                            logic [15:0] o, int exp);
        mode = md; frq = f; ampl = a; ofst = o; cycl = 16'd0;
        run = 1'b1;
        idle(2);
        cap.delete();
        ticks(1, 1);
        idle(4);
        lit = '{exp};
        check_cap(nm);
        run = 1'b0;
        idle(3);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle(3);
        chk("reset_sample", int'(sample), 0);
        chk("reset_valid", int'(valid), 0);
        rst = 1'b0;
        idle(2);

        // Sawtooth, quarter-turn steps
        mode = 3'd1; frq = 32'h4000_0000; ampl = 16'h8000; ofst = 16'd0; cycl = 16'd0;
        run = 1'b1;
        idle(2);
        cap.delete();
        ticks(8, 4);
        idle(4);
        lit = '{-32768, -16384, 0, 16384, -32768, -16384, 0, 16384};
        check_cap("saw");
        run = 1'b0;
        idle(3);

        // Square with 3/8 duty
        mode = 3'd3; frq = 32'h2000_0000; dcyc = 16'h6000;
        run = 1'b1;
        idle(2);
        cap.delete();
        ticks(8, 3);
        idle(4);
        lit = '{32767, 32767, 32767, -32768, -32768, -32768, -32768, -32768};
        check_cap("square");
        run = 1'b0;
        idle(3);

        // Triangle with a two-cycle budget
        mode = 3'd2; frq = 32'h4000_0000; cycl = 16'd2;
        run = 1'b1;
        idle(2);
        cap.delete();
        done_cnt = 0;
        ticks(10, 4);
        idle(4);
        lit = '{-32768, 0, 32767, -1, -32768, 0, 32767, -1};
        check_cap("triangle");
        chk("done_pulses", done_cnt, 1);
        chk("busy_in_done", int'(busy), 0);
        run = 1'b0;
        idle(3);

        // Saturation corners
        one_shot("sat_dc_pos", 3'd0, 32'h0, 16'h8000, 16'd1000, 32767);
        one_shot("sat_dc_neg", 3'd0, 32'h0, 16'h8000, 16'(-1000), 31767);
        one_shot("sat_saw_gain", 3'd1, 32'h0, 16'hFFFF, 16'd0, -32768);

        // Run drop while samples are in flight
        mode = 3'd1; frq = 32'h1000_0000; ampl = 16'h8000; ofst = 16'd0; cycl = 16'd0;
        run = 1'b1;
        idle(2);
        cap.delete();
        tick = 1'b1;
        idle(2);
        tick = 1'b0;
        run  = 1'b0;
        idle(6);
        chk("run_drop_valids", cap.size(), 1);

        // Async reset mid-pipeline with run held high
        run = 1'b1;
        idle(2);
        tick = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("areset_sample", int'(sample), 0);
        chk("areset_valid", int'(valid), 0);
        chk("areset_busy", int'(busy), 0);
        @(negedge clk);
        tick = 1'b0;
        idle(1);
        rst = 1'b0;
        @(posedge clk);
        #1 chk("rerun_busy", int'(busy), 1);
        @(negedge clk);
        cap.delete();
        ticks(1, 1);
        idle(4);
        lit = '{-32768};
        check_cap("rerun_first");
        run = 1'b0;
        idle(3);

        // Sine (or zero when the ROM is not built)
        mode = 3'd4; frq = 32'h4000_0000; ampl = 16'h8000; ofst = 16'd0; cycl = 16'd0;
        run = 1'b1;
        idle(2);
        cap.delete();
        ticks(4, 3);
        idle(4);
`ifdef WAVEGEN_SINE_EN
        lit = '{0, 32767, 0, -32767};
`else
        lit = '{0, 0, 0, 0};
`endif
        check_cap("sine");
        run = 1'b0;
        idle(3);

        // Randomized run against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(39) == 0) run = ~run;
            tick = ($urandom_range(2) == 0);
            if ($urandom_range(9) == 0) begin
                mode = 3'($urandom_range(7));
                frq  = ($urandom_range(1) == 0) ? $urandom : ($urandom | 32'h4000_0000);
                ampl = 16'($urandom);
                ofst = 16'($urandom);
                dcyc = 16'($urandom);
                cycl = 16'($urandom_range(3));
            end
            idle(1);
        end
        tick = 1'b0;
        run  = 1'b0;
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
